// File: rtl/hyperbus_tf_arbiter.sv
// Round-robin arbiter that shares the single HyperBus PHY transfer port between NumReq requesters.
// Optional WAIT_DONE watchdog is compiled in when HYPERBUS_ARB_TIMEOUT_EN is defined.
module hyperbus_tf_arbiter #(
    parameter int NumReq        = 2,
    parameter int IdW           = (NumReq > 1) ? $clog2(NumReq) : 1,
    parameter int TimeoutCycles = 1024,
    parameter int TfW           = 43
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  logic [NumReq*TfW-1:0] req_tf_i,
    output logic                  tf_valid_o,
    input  logic                  tf_ready_i,
    output logic [TfW-1:0]        tf_o,
    output logic [IdW-1:0]        tf_id_o,
    input  logic                  xfer_done_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   tf_id_q, tf_id_d;
    logic [TfW-1:0]   tf_q, tf_d;
    logic [IdW-1:0]   winner;
    logic [IdW-1:0]   next_ptr;
    logic             any_valid;
    logic             timeout_evt;

    // Search from the highest offset down so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (req_valid_i[idx]) begin
                any_valid = 1'b1;
                winner    = IdW'(idx);
            end
        end
    end

    assign next_ptr = (tf_id_q == IdW'(NumReq - 1)) ? '0 : tf_id_q + IdW'(1);

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A completion arriving in the same cycle as the limit takes precedence over the watchdog.
    always_comb begin
        cnt_d       = cnt_q;
        timeout_evt = (state_q == WAIT_DONE) && !xfer_done_i && (cnt_q == CntW'(TimeoutCycles));
        if (state_q != WAIT_DONE) begin
            cnt_d = '0;
        end else if (!xfer_done_i && !timeout_evt) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign timeout_evt = 1'b0;
`endif

    // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tf_d        = tf_q;
        tf_id_d     = tf_id_q;
        req_ready_o = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_o[winner] = !rst_i;
                    tf_d                = req_tf_i[int'(winner)*TfW +: TfW];
                    tf_id_d             = winner;
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                if (tf_ready_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (xfer_done_i || timeout_evt) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous and all state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            tf_q     <= '0;
            tf_id_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tf_q     <= tf_d;
            tf_id_q  <= tf_id_d;
        end
    end

    assign tf_valid_o = (state_q == ISSUE);
    assign busy_o     = (state_q != IDLE);
    assign tf_o       = tf_q;
    assign tf_id_o    = tf_id_q;
    assign timeout_o  = timeout_evt && !rst_i;

endmodule

// File: tb/tb_hyperbus_tf_arbiter.sv
// Self-checking bench for hyperbus_tf_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations (reset, single, round-robin, spurious done, reset, watchdog).
module tb_hyperbus_tf_arbiter;

    localparam int N   = 2;
    localparam int TFW = 43;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [TFW-1:0] req_tf [N];
    logic [N*TFW-1:0] req_tf_flat;
    logic           tf_valid;
    logic           tf_ready;
    logic [TFW-1:0] tf;
    logic [0:0]     tf_id;
    logic           xfer_done;
    logic           busy;
    logic           timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    assign req_tf_flat = {req_tf[1], req_tf[0]};

    hyperbus_tf_arbiter #(
        .NumReq       (N),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_tf_i   (req_tf_flat),
        .tf_valid_o (tf_valid),
        .tf_ready_i (tf_ready),
        .tf_o       (tf),
        .tf_id_o    (tf_id),
        .xfer_done_i(xfer_done),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    // Descriptor layout used by the bench: {write, burst[9:0], address[31:0]}.
    function automatic logic [TFW-1:0] mk_tf(logic [31:0] addr, logic wr, logic [9:0] burst);
        return {wr, burst, addr};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!tf_valid && n < 20) begin
            step();
            n++;
        end
        check(name, 64'(tf_valid), 64'd1);
    endtask

    // Reference model: a priority list rotated after each completed transfer, plus the owner of the PHY.
    typedef enum int { M_FREE, M_OFFER, M_OWNED } mphase_e;
    mphase_e        m_phase = M_FREE;
    int             order[$] = '{0, 1};
    int             m_id = 0;
    logic [TFW-1:0] m_tf = '0;
    int             m_wait = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            int             w;
            logic [N-1:0]   exp_ready;
            logic           exp_to;
            w = -1;
            foreach (order[i]) if (w < 0 && req_valid[order[i]]) w = order[i];
            exp_ready = '0;
            if (!rst && m_phase == M_FREE && w >= 0) exp_ready[w] = 1'b1;
            exp_to = 1'b0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
            exp_to = !rst && m_phase == M_OWNED && m_wait == TMO && !xfer_done;
`endif
            check("model_req_ready", 64'(req_ready), 64'(exp_ready));
            check("model_tf_valid", 64'(tf_valid), 64'(m_phase == M_OFFER));
            check("model_busy", 64'(busy), 64'(m_phase != M_FREE));
            check("model_tf", 64'(tf), 64'(m_tf));
            check("model_tf_id", 64'(tf_id), 64'(m_id));
            check("model_timeout", 64'(timeout), 64'(exp_to));
            if (rst) begin
                m_phase = M_FREE;
                order   = '{0, 1};
                m_id    = 0;
                m_tf    = '0;
                m_wait  = 0;
            end else begin
                case (m_phase)
                    M_FREE: if (w >= 0) begin
                        m_tf    = req_tf[w];
                        m_id    = w;
                        m_phase = M_OFFER;
                    end
                    M_OFFER: if (tf_ready) begin
                        m_phase = M_OWNED;
                        m_wait  = 0;
                    end
                    M_OWNED: if (xfer_done || exp_to) begin
                        order.delete();
                        for (int k = 0; k < N; k++) order.push_back((m_id + 1 + k) % N);
                        m_phase = M_FREE;
                    end else begin
                        m_wait++;
                    end
                    default: m_phase = M_FREE;
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    int grants[$];
    int exp_grants[4] = '{0, 1, 0, 1};

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        tf_ready  = 1'b0;
        xfer_done = 1'b0;
        req_tf[0] = mk_tf(32'h0000_2000, 1'b0, 10'd3);
        req_tf[1] = mk_tf(32'h0000_1000, 1'b1, 10'd7);

        // T1: reset held three cycles with all requesters valid.
        step();
        chk_en = 1'b1;
        step();
        step();
        check("t1_ready_in_reset", 64'(req_ready), 64'd0);
        check("t1_busy_in_reset", 64'(busy), 64'd0);
        check("t1_tf_valid_in_reset", 64'(tf_valid), 64'd0);
        check("t1_tf_in_reset", 64'(tf), 64'd0);
        rst = 1'b0;
        #1;
        check("t1_first_grant", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("t1_issue_valid", 64'(tf_valid), 64'd1);
        check("t1_issue_id", 64'(tf_id), 64'd0);
        tf_ready = 1'b1;
        step();
        tf_ready = 1'b0;
        check("t1_wait_busy", 64'(busy), 64'd1);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;

        // T2: single request from req1 with PHY ready delayed.
        req_valid = 2'b10;
        #1;
        check("t2_ready_req1", 64'(req_ready), 64'b10);
        step();
        req_valid = 2'b00;
        #1;
        check("t2_tf_id", 64'(tf_id), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t2_tf_valid_held", 64'(tf_valid), 64'd1);
            check("t2_tf_stable", 64'(tf), 64'(mk_tf(32'h0000_1000, 1'b1, 10'd7)));
            step();
        end
        tf_ready = 1'b1;
        step();
        tf_ready = 1'b0;
        check("t2_valid_dropped", 64'(tf_valid), 64'd0);
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;

        // T3: both requesters continuously valid, done five cycles after each issue.
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_valid("t3_wait_issue");
            grants.push_back(int'(tf_id));
            tf_ready = 1'b1;
            step();
            tf_ready = 1'b0;
            repeat (4) step();
            xfer_done = 1'b1;
            #1;
            check("t3_no_grant_in_done_cycle", 64'(req_ready), 64'd0);
            step();
            xfer_done = 1'b0;
        end
        req_valid = 2'b00;
        check("t3_grant_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t3_grant_order", 64'(grants[i]), 64'(exp_grants[i]));

        // T4: spurious done in IDLE and in ISSUE.
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        #1;
        check("t4_idle_after_spurious", 64'(busy), 64'd0);
        req_valid = 2'b11;
        #1;
        check("t4_ptr_unchanged", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        #1;
        check("t4_still_issue", 64'(tf_valid), 64'd1);
        tf_ready = 1'b1;
        step();
        tf_ready = 1'b0;
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;
        req_valid = 2'b11;
        #1;
        check("t4_next_is_req1", 64'(req_ready), 64'b10);

        // T5: reset while req1's transfer is in WAIT_DONE.
        step();
        req_valid = 2'b00;
        tf_ready  = 1'b1;
        step();
        tf_ready = 1'b0;
        check("t5_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy_cleared", 64'(busy), 64'd0);
        check("t5_tf_valid_cleared", 64'(tf_valid), 64'd0);
        check("t5_tf_cleared", 64'(tf), 64'd0);
        check("t5_id_cleared", 64'(tf_id), 64'd0);
        req_valid = 2'b11;
        #1;
        check("t5_ptr_reset", 64'(req_ready), 64'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("t5_fresh_tf", 64'(tf), 64'(mk_tf(32'h0000_2000, 1'b0, 10'd3)));
        tf_ready = 1'b1;
        step();
        tf_ready = 1'b0;
        xfer_done = 1'b1;
        step();
        xfer_done = 1'b0;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
        // T6: watchdog fires 16 cycles after WAIT_DONE entry; a done on that cycle suppresses it.
        begin
            int k;
            req_valid = 2'b11;
            #1;
            check("t6_grant_req1", 64'(req_ready), 64'b10);
            step();
            req_valid = 2'b00;
            tf_ready  = 1'b1;
            step();
            tf_ready = 1'b0;
            k = 0;
            while (!timeout && k < 40) begin
                step();
                k++;
            end
            check("t6_timeout_latency", 64'(k), 64'd16);
            step();
            req_valid = 2'b11;
            #1;
            check("t6_next_after_timeout", 64'(req_ready), 64'b01);
            step();
            req_valid = 2'b00;
            tf_ready  = 1'b1;
            step();
            tf_ready = 1'b0;
            repeat (TMO) step();
            xfer_done = 1'b1;
            #1;
            check("t6_done_wins", 64'(timeout), 64'd0);
            step();
            xfer_done = 1'b0;
            #1;
            check("t6_idle_after_done", 64'(busy), 64'd0);
        end
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
